// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one single-ported req/ack memory between the
// IF stage (loads only) and the MEM stage (loads and stores).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | bus free; arbitrate on every edge
// D_WAIT | MEM-stage access on the bus, waiting for mem_ack or timeout
// I_WAIT | IF-stage access on the bus, waiting for mem_ack or timeout
//
// A requester whose ready pulse is high in the current cycle is left out of
// arbitration. That gives the other side the bus first, and the served side
// cannot be granted again until the following edge. MEM normally has
// priority over IF. After STARVE_MAX consecutive MEM grants with IF waiting,
// IF wins the next arbitration.
module mem_port_arbiter #(
  parameter int W          = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         if_req,
  input  logic [W-1:0] if_addr,
  output logic [W-1:0] if_rdata,
  output logic         if_ready,
  input  logic         d_load_en,
  input  logic         d_store_en,
  input  logic [W-1:0] d_addr,
  input  logic [W-1:0] d_wdata,
  output logic [W-1:0] d_rdata,
  output logic         d_ready,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_ack,
  output logic         bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_WAIT = 2'd1,
    I_WAIT = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [SW-1:0] starve_cnt;
  logic          d_pend;
  logic          i_pend;
  logic          i_wins;
  logic          d_wins;

  // Arbitration: exclude whoever is being told "done" this cycle, MEM first unless IF is starved
  always_comb begin
    d_pend = (d_load_en | d_store_en) & ~d_ready;
    i_pend = if_req & ~if_ready;
    i_wins = i_pend & (~d_pend | (starve_cnt == STARVE_TOP));
    d_wins = d_pend & ~i_wins;
  end

  // Sequencer: grant, hold the bus transaction, complete on ack or abort on watchdog expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      if_ready   <= 1'b0;
      d_rdata    <= '0;
      d_ready    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_wins) begin
            state      <= I_WAIT;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
          end else if (d_wins) begin
            state     <= D_WAIT;
            mem_req   <= 1'b1;
            // load and store both asserted is treated as a store
            mem_we    <= d_store_en;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            wait_cnt  <= '0;
            if (if_req && (starve_cnt != STARVE_TOP)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        D_WAIT, I_WAIT: begin
          if (mem_ack) begin
            // an ack on the last watchdog cycle still counts as a normal completion
            state   <= IDLE;
            mem_req <= 1'b0;
            if (state == I_WAIT) begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              d_ready <= 1'b1;
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            bus_err  <= 1'b1;
            wait_cnt <= wait_cnt + 1'b1;
            if (state == I_WAIT) begin
              if_ready <= 1'b1;
              if_rdata <= '1;
            end else begin
              d_ready <= 1'b1;
              d_rdata <= '1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
